// File: rtl/glitch_stream_checker.sv
// glitch_stream_checker: multi-channel armed-window output comparator.
// Optional GLITCH_CHECKER_PERCHAN_EN adds per-channel error counters.
module glitch_stream_checker #(
    parameter int pCHANNELS  = 4,
    parameter int pCNT_WIDTH = 32,
    parameter int pSETTLE    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  stop,
    input  logic [pCNT_WIDTH-1:0] check_len,
    input  logic                  valid,
    input  logic [pCHANNELS-1:0]  actual,
    input  logic [pCHANNELS-1:0]  expected,
    input  logic [pCHANNELS-1:0]  mask,
    output logic [1:0]            state,
    output logic                  done,
    output logic [pCHANNELS-1:0]  mismatch,
    output logic [pCHANNELS-1:0]  sticky_err,
    output logic [pCNT_WIDTH-1:0] compare_count,
    output logic [pCNT_WIDTH-1:0] error_count,
    output logic [pCNT_WIDTH-1:0] first_err_idx,
    output logic [pCHANNELS-1:0]  first_err_vec,
    output logic                  first_err_valid
`ifdef GLITCH_CHECKER_PERCHAN_EN
    ,
    output logic [pCHANNELS*pCNT_WIDTH-1:0] chan_err_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int SW = (pSETTLE > 1) ? $clog2(pSETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LD = SW'(pSETTLE);
    localparam logic [SW-1:0] SETTLE_ONE = SW'(1);
    localparam logic [pCNT_WIDTH-1:0] CNT_ONE = pCNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [pCHANNELS-1:0]    mis_q, mis_d;
    logic [pCHANNELS-1:0]    sticky_q, sticky_d;
    logic [pCNT_WIDTH-1:0]   ccnt_q, ccnt_d;
    logic [pCNT_WIDTH-1:0]   ecnt_q, ecnt_d;
    logic [pCNT_WIDTH-1:0]   fidx_q, fidx_d;
    logic [pCHANNELS-1:0]    fvec_q, fvec_d;
    logic                    fval_q, fval_d;

    logic [pCHANNELS-1:0]    m;
    logic                    any_err;
    logic                    cc_sat;
    logic                    ec_sat;
    logic [pCNT_WIDTH-1:0]   cc_inc;

    // Masked per-sample compare and counter saturation flags
    always_comb begin
        m       = (actual ^ expected) & mask;
        any_err = |m;
        cc_sat  = &ccnt_q;
        ec_sat  = &ecnt_q;
        cc_inc  = ccnt_q + CNT_ONE;
    end

    // Window FSM next state plus result accumulation
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        mis_d    = '0;
        sticky_d = sticky_q;
        ccnt_d   = ccnt_q;
        ecnt_d   = ecnt_q;
        fidx_d   = fidx_q;
        fvec_d   = fvec_q;
        fval_d   = fval_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    sticky_d = '0;
                    ccnt_d   = '0;
                    ecnt_d   = '0;
                    fidx_d   = '0;
                    fvec_d   = '0;
                    fval_d   = 1'b0;
                    if (pSETTLE > 0) begin
                        state_d  = S_SETTLE;
                        settle_d = SETTLE_LD;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_SETTLE: begin
                if (stop) begin
                    state_d = S_DONE;
                end else if (settle_q <= SETTLE_ONE) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - SETTLE_ONE;
                end
            end
            S_CHECK: begin
                if (valid) begin
                    mis_d = m;
                    if (!cc_sat) begin
                        ccnt_d = cc_inc;
                    end
                    if (any_err) begin
                        if (!ec_sat) begin
                            ecnt_d = ecnt_q + CNT_ONE;
                        end
                        sticky_d = sticky_q | m;
                        if (!fval_q) begin
                            fidx_d = ccnt_q;
                            fvec_d = m;
                            fval_d = 1'b1;
                        end
                    end
                    // A saturated count never closes the window
                    if (!cc_sat && (check_len != '0)
                        && (cc_inc == check_len)) begin
                        state_d = S_DONE;
                    end
                end
                if (stop) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    // Result and state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            settle_q <= '0;
            mis_q    <= '0;
            sticky_q <= '0;
            ccnt_q   <= '0;
            ecnt_q   <= '0;
            fidx_q   <= '0;
            fvec_q   <= '0;
            fval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            settle_q <= settle_d;
            mis_q    <= mis_d;
            sticky_q <= sticky_d;
            ccnt_q   <= ccnt_d;
            ecnt_q   <= ecnt_d;
            fidx_q   <= fidx_d;
            fvec_q   <= fvec_d;
            fval_q   <= fval_d;
        end
    end

    assign state           = state_q;
    assign done            = done_q;
    assign mismatch        = mis_q;
    assign sticky_err      = sticky_q;
    assign compare_count   = ccnt_q;
    assign error_count     = ecnt_q;
    assign first_err_idx   = fidx_q;
    assign first_err_vec   = fvec_q;
    assign first_err_valid = fval_q;

`ifdef GLITCH_CHECKER_PERCHAN_EN
    logic [pCNT_WIDTH-1:0] pc_q [pCHANNELS];
    logic [pCNT_WIDTH-1:0] pc_d [pCHANNELS];
    logic                  pc_clr;
    logic                  pc_smp;

    assign pc_clr = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign pc_smp = valid && (state_q == S_CHECK);

    // Per-channel saturating error counters
    always_comb begin
        for (int i = 0; i < pCHANNELS; i++) begin
            pc_d[i] = pc_q[i];
            if (pc_clr) begin
                pc_d[i] = '0;
            end else if (pc_smp && m[i] && !(&pc_q[i])) begin
                pc_d[i] = pc_q[i] + CNT_ONE;
            end
        end
    end

    // Per-channel counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < pCHANNELS; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < pCHANNELS; i++) begin
                pc_q[i] <= pc_d[i];
            end
        end
    end

    for (genvar g = 0; g < pCHANNELS; g++) begin : g_pc
        assign chan_err_count[g*pCNT_WIDTH +: pCNT_WIDTH] = pc_q[g];
    end
`endif

endmodule

// File: doc/glitch_stream_checker.md
# glitch_stream_checker

Parametrised multi-channel output checker for the cocotb top-level wrappers. It compares N DUT output bits (glitch outputs, trigger lines, target IO) against testbench-supplied expected values over an armed window. It keeps sticky per-channel error flags, a saturating error count and the index of the first mismatch. It replaces ad-hoc single-bit glitch error flops, adding masking, a settle period and bounded check windows.

## Interface
- pCHANNELS, 4, number of compared bits (1–32)
- pCNT_WIDTH, 32, width of compare and error counters
- pSETTLE, 8, cycles ignored after arm before checking starts (0 allowed)
- clk  in  1  checker clock; sampling is on the rising edge
- reset  in  1  asynchronous, active-high; one clock, no other reset
- arm  in  1  start-window pulse
- stop  in  1  end-window pulse
- check_len  in  pCNT_WIDTH  valid samples per window; 0 = unbounded
- valid  in  1  sample qualifier
- actual  in  pCHANNELS  DUT outputs
- expected  in  pCHANNELS  expected outputs
- mask  in  pCHANNELS  1 = channel checked
- state  out  2  IDLE=0, SETTLE=1, CHECK=2, DONE=3
- done  out  1  high in DONE
- mismatch  out  pCHANNELS  registered per-cycle mismatch vector
- sticky_err  out  pCHANNELS  OR of all mismatches this window
- compare_count  out  pCNT_WIDTH  valid samples checked (saturating)
- error_count  out  pCNT_WIDTH  samples with any mismatch (saturating)
- first_err_idx  out  pCNT_WIDTH  compare_count value at first mismatch
- first_err_vec  out  pCHANNELS  mismatch vector at first mismatch
- first_err_valid  out  1  first_err_* captured

## Operation
- Reset: state=IDLE; all outputs are 0.
- IDLE/DONE + arm: clear mismatch, sticky_err, counters, first_err_*.
  - pSETTLE>0: go to SETTLE and load the settle counter with pSETTLE.
  - pSETTLE=0: go directly to CHECK.
- SETTLE: decrement every clock regardless of valid. When the count reaches 1, go to CHECK next cycle. Exactly pSETTLE cycles are spent in SETTLE.
- CHECK, valid=1:
  - m = (actual ^ expected) & mask; mismatch <= m.
  - compare_count++.
  - If m != 0: error_count++ (once per sample, not per channel) and sticky_err |= m.
  - If m != 0 and first_err_valid=0: first_err_idx <= pre-increment compare_count, first_err_vec <= m, first_err_valid <= 1.
- CHECK, valid=0: mismatch <= 0; counters hold.
- Window end:
  - CHECK with check_len != 0 and the post-increment compare_count == check_len: go to DONE.
  - stop in SETTLE or CHECK: go to DONE.
  - stop together with a valid sample in CHECK: the sample is checked first, then DONE.
- DONE: all results hold; mismatch <= 0. An arm starts a new window.
- Ignored inputs: arm in SETTLE/CHECK; stop in IDLE/DONE. Arm and stop together in IDLE/DONE: arm wins.
- Counters saturate at all-ones. The count-based window end is never hit after saturation; stop is then required.
- Reset mid-window: immediate return to the reset state; no partial results are retained.

## Timing
- Single clock domain; all outputs are registered.
- Latency: the sample at edge k appears on mismatch, counters and sticky_err after edge k; state=DONE is visible after the same edge.
- arm at edge k: state=SETTLE (or CHECK when pSETTLE=0) after edge k. The first sample checked is at edge k+pSETTLE+1.
- Asynchronous reset assertion clears outputs without a clock. Deassertion must be synchronous to clk; this is the testbench's responsibility.

## Configuration
- GLITCH_CHECKER_PERCHAN_EN defined: adds output chan_err_count (pCHANNELS×pCNT_WIDTH, packed, channel 0 in the LSBs).
  - One saturating counter per channel, incremented on each checked sample where that bit of m is set.
  - Cleared on arm; reset to 0.
- Macro undefined: port and counters are absent; all other behaviour is identical.

## Test plan
- Match run: pCHANNELS=4, pSETTLE=2, check_len=10, actual=expected for 10 valid cycles → DONE after the 10th sample; compare_count=10, error_count=0, sticky_err=0, first_err_valid=0.
- Single error: mismatch on bit 2 at sample 5 (0-based), mask=4'hF → error_count=1, first_err_idx=5, first_err_vec=4'b0100, sticky_err=4'b0100, mismatch pulses one cycle.
- Masking and multi-bit: bits 0 and 3 wrong on samples 1 and 4, mask=4'b0111 → error_count=2, first_err_idx=1, first_err_vec=4'b0001, sticky_err=4'b0001.
- Settle and control edges:
  - Mismatches during the 2 SETTLE cycles → not counted.
  - stop with a mismatching valid sample → error_count=1, then DONE.
  - arm in CHECK → ignored.
- Saturation/unbounded: pCNT_WIDTH=4, check_len=0, 20 all-mismatch samples → compare_count=error_count=15; stays in CHECK until stop.
- Reset mid-CHECK → state=0 and all outputs 0 immediately. With GLITCH_CHECKER_PERCHAN_EN, chan_err_count counts per bit (e.g. 3 errors on bit 1 → field 1 = 3).
